// File: rtl/lsu_rmw.sv
// RV32I load/store unit: word-wide access to data_mem with lane extraction,
// sign/zero extension and read-modify-write for byte/half stores.
module lsu_rmw #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // IDLE   | ready for a request; done/fault pulse appears here
  // LOAD   | word read, lane extracted into rdata
  // STORE  | full-word write
  // RMW_RD | read word, merge new byte/half into merge_q
  // RMW_WR | write merged word back
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR} state_t;

  localparam logic [31:0] ADDR_LIM = 32'(4 * MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  logic        req_fault;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    req_fault = 1'b0;
    case (req_funct3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = req_addr[0];
      3'b010:  req_fault = (req_addr[1:0] != 2'b00);
      3'b100:  req_fault = req_write;
      3'b101:  req_fault = req_write | req_addr[0];
      default: req_fault = 1'b1;
    endcase
    // full 32-bit compare, so huge addresses never alias into the array
    if (req_addr >= ADDR_LIM) req_fault = 1'b1;
  end

  always_comb begin
    lane_b = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: lane_b = mem_rdata[7:0];
      2'd1: lane_b = mem_rdata[15:8];
      2'd2: lane_b = mem_rdata[23:16];
      2'd3: lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = mem_rdata;
    case (f3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'h0, lane_b};
      3'b101:  load_val = {16'h0, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_fault) begin
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            f3_d    = req_funct3;
            if (!req_write)                state_d = LOAD;
            else if (req_funct3 == 3'b010) state_d = STORE;
            else                           state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        rdata_d = load_val;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      STORE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RMW_RD: begin
        merge_d = merged;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // strobes decode straight from state so reset kills a pending write at once
  assign req_ready = (state_q == IDLE);
  assign MemRead   = (state_q == LOAD) || (state_q == RMW_RD);
  assign MemWrite  = (state_q == STORE) || (state_q == RMW_WR);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = (state_q == STORE)  ? wdata_q :
                     (state_q == RMW_WR) ? merge_q : 32'h0;
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: directed plan then random traffic against a
// word-array reference model; a monitor checks every done pulse and write.
module tb_lsu_rmw;
  localparam int MW = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, done, fault, MemRead, MemWrite;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  lsu_rmw #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .done(done), .rdata(rdata), .fault(fault),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit flt; bit is_load; logic [31:0] rd; int cyc; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wexp_t;
  exp_t  eq[$];
  wexp_t wq[$];

  logic [31:0] mem [MW];
  logic [31:0] ref_mem [MW];
  bit          fill_mem;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] pat(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  assign mem_rdata = MemRead ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill_mem) for (int i = 0; i < MW; i++) mem[i] <= pat(i);
    else if (MemWrite) mem[mem_addr[9:2]] <= mem_wdata;
  end

  function automatic bit ref_fault(bit w, logic [2:0] f3, logic [31:0] a);
    if (a >= 32'(4 * MW)) return 1'b1;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (w && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    logic [31:0] w, v;
    int off;
    w = ref_mem[a / 4];
    off = int'(a % 4);
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (8 * off)) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_store(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    logic [31:0] mask;
    int off;
    off = int'(a % 4);
    case (f3)
      3'd0:    mask = 32'hFF << (8 * off);
      3'd1:    mask = 32'hFFFF << (8 * off);
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (ref_mem[a / 4] & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // call at a negedge with the unit idle; leaves req_valid high for 'hold' cycles
  task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input bit track);
    exp_t  e;
    wexp_t we;
    e.flt = ref_fault(w, f3, a);
    e.is_load = !w;
    e.rd = 32'h0;
    e.cyc = cyc + (e.flt ? 1 : (w && f3 != 3'd2) ? 3 : 2);
    if (track) begin
      if (!e.flt) begin
        if (!w) e.rd = ref_load(f3, a);
        else begin
          we.addr = a & 32'hFFFF_FFFC;
          we.data = ref_store(f3, a, wd);
          ref_mem[a / 4] = we.data;
          wq.push_back(we);
        end
      end
      eq.push_back(e);
    end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    repeat (hold) @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) return;
      @(negedge clk);
    end
    n_vec++; n_err++;
    $display("FAIL done_timeout: no done within 8 cycles at cycle %0d", cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_done"},  {31'h0, done},      32'h0);
    chk({tag, "_fault"}, {31'h0, fault},     32'h0);
    chk({tag, "_rdata"}, rdata,              32'h0);
    chk({tag, "_memrd"}, {31'h0, MemRead},   32'h0);
    chk({tag, "_memwr"}, {31'h0, MemWrite},  32'h0);
    chk({tag, "_maddr"}, mem_addr,           32'h0);
    chk({tag, "_mwdat"}, mem_wdata,          32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (MemRead && MemWrite) begin
        n_vec++; n_err++;
        $display("FAIL rd_wr_overlap: MemRead=1 MemWrite=1 at cycle %0d", cyc);
      end
      if (done) begin : mon_done
        exp_t e;
        n_vec++;
        if (eq.size() == 0) begin
          n_err++;
          $display("FAIL done_unexpected: done at cycle %0d with nothing outstanding", cyc);
        end else begin
          e = eq.pop_front();
          if (fault !== e.flt || cyc != e.cyc || (e.is_load && !e.flt && rdata !== e.rd)) begin
            n_err++;
            $display("FAIL resp: got fault=%b cyc=%0d rdata=%h, expected fault=%b cyc=%0d rdata=%h",
                     fault, cyc, rdata, e.flt, e.cyc, e.rd);
          end
        end
      end else if (fault) begin
        n_vec++; n_err++;
        $display("FAIL fault_without_done at cycle %0d", cyc);
      end
      if (MemWrite) begin : mon_wr
        wexp_t we;
        n_vec++;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected: addr %h data %h", mem_addr, mem_wdata);
        end else begin
          we = wq.pop_front();
          if (mem_addr !== we.addr || mem_wdata !== we.data) begin
            n_err++;
            $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                     mem_addr, mem_wdata, we.addr, we.data);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    bit          w;
    rst_n = 1'b0; fill_mem = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < MW; i++) ref_mem[i] = pat(i);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1; fill_mem = 1'b0;
    @(negedge clk);

    issue(1, 3'd2, 32'd4, 32'h1234_5678, 1, 1); wait_done();
    issue(0, 3'd2, 32'd4, 32'h0, 1, 1); wait_done();
    chk("lw4", rdata, 32'h1234_5678);
    issue(1, 3'd0, 32'd5, 32'hFFFF_FFAB, 1, 1); wait_done();
    chk("sb5_word", mem[1], 32'h1234_AB78);
    issue(0, 3'd0, 32'd5, 32'h0, 1, 1); wait_done();
    chk("lb5", rdata, 32'hFFFF_FFAB);
    issue(0, 3'd4, 32'd5, 32'h0, 1, 1); wait_done();
    chk("lbu5", rdata, 32'h0000_00AB);
    issue(0, 3'd1, 32'd6, 32'h0, 1, 1); wait_done();
    chk("lh6", rdata, 32'h0000_1234);
    issue(0, 3'd5, 32'd4, 32'h0, 1, 1); wait_done();
    chk("lhu4", rdata, 32'h0000_AB78);

    issue(0, 3'd2, 32'd6, 32'h0, 1, 1); wait_done();
    chk("f_lw6", {31'h0, fault}, 32'h1);
    issue(1, 3'd1, 32'd3, 32'h5555, 1, 1); wait_done();
    chk("f_sh3", {31'h0, fault}, 32'h1);
    issue(0, 3'd2, 32'(4 * MW), 32'h0, 1, 1); wait_done();
    chk("f_lw_top", {31'h0, fault}, 32'h1);
    issue(0, 3'd3, 32'd0, 32'h0, 1, 1); wait_done();
    chk("f_f3_011", {31'h0, fault}, 32'h1);
    issue(0, 3'd2, 32'(4 * MW - 4), 32'h0, 1, 1); wait_done();
    chk("lw_last_ok", {31'h0, fault}, 32'h0);

    // back-to-back, first request held through its busy cycle
    issue(0, 3'd2, 32'd0, 32'h0, 2, 1); wait_done();
    issue(0, 3'd2, 32'd8, 32'h0, 1, 1); wait_done();
    repeat (3) @(negedge clk);

    // reset during RMW_RD; the write must never appear
    issue(1, 3'd0, 32'd8, 32'h0000_00CD, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk("abort_memwr", {31'h0, MemWrite}, 32'h0);
    @(negedge clk);
    chk_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);

    for (int n = 0; n < 200; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(4 * MW, 4 * MW + 40));
        1:       a = $urandom() | 32'h8000_0000;
        default: a = 32'($urandom_range(0, 4 * MW - 1));
      endcase
      issue(w, f3, a, $urandom(), 1, 1);
      wait_done();
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(eq.size()), 32'h0);
    chk("writes_drained", 32'(wq.size()), 32'h0);
    for (int i = 0; i < MW; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit between the single-cycle core's execute stage and data_mem.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on data_mem's MemRead/MemWrite/addr/write_data/read_data interface.
- Handles byte-lane extraction and sign/zero extension, and performs read-modify-write for sub-word stores.
- Stalls the core with a ready/done handshake; flags misaligned, out-of-range and illegal accesses.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in data_mem; legal byte addresses are 0 .. 4*MEM_WORDS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents a memory request.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte, half or word is used.
- req_ready  out  1  unit idle; a request is accepted when req_valid & req_ready.
- done  out  1  one-cycle pulse: request completed.
- rdata  out  32  extended load result, valid while done=1 for loads.
- fault  out  1  one-cycle pulse with done: request rejected, no memory access made.
- MemRead  out  1  to data_mem.
- MemWrite  out  1  to data_mem; the write commits on the rising clk edge.
- mem_addr  out  32  word-aligned address to data_mem (bits[1:0]=00).
- mem_wdata  out  32  to data_mem write_data.
- mem_rdata  in  32  from data_mem read_data; combinational from mem_addr while MemRead=1.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, req_ready=1, done=0, fault=0, rdata=0, MemRead=0, MemWrite=0, mem_addr=0, mem_wdata=0.
- Abort on reset: rst_n asserted mid-operation abandons the request immediately; MemWrite drops asynchronously, so a pending RMW write never commits.
- State machine states: IDLE, LOAD, STORE, RMW_RD, RMW_WR.
- IDLE: req_ready=1. On accept, latch addr/funct3/wdata/write into internal registers.
- Fault check at accept. Fault is raised when any of these holds:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr >= 4*MEM_WORDS.
  - funct3 in {011,110,111}.
  - Store with funct3 in {100,101}.
- Fault response: stay in IDLE; next cycle done=1 and fault=1; rdata unchanged; no MemRead/MemWrite.
- Accepted load: go to LOAD.
- Accepted store: funct3=010 goes to STORE; otherwise goes to RMW_RD.
- LOAD: MemRead=1, mem_addr={addr[31:2],2'b00}.
  - At the edge, rdata <= extracted lane, done <= 1; go to IDLE.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B and H sign-extend; BU and HU zero-extend.
- STORE: MemWrite=1, mem_wdata=req_wdata. At the edge, done <= 1; go to IDLE.
- RMW_RD: MemRead=1. At the edge, merge reg <= mem_rdata with the target byte or half replaced by req_wdata[7:0] or [15:0]; go to RMW_WR.
- RMW_WR: MemWrite=1, mem_wdata=merge reg, same mem_addr. At the edge, done <= 1; go to IDLE.
- Outside active states: MemRead and MemWrite are 0.
- MemRead and MemWrite are never both 1.
- req_ready=0 in every state except IDLE. req_valid is ignored while not ready.
- Latency from accept edge to the done cycle:
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Fault: 1 cycle.
- Back-to-back requests: done occurs in IDLE, so a new request may be accepted in the same cycle done=1. Throughput is one load/SW per 2 cycles.
- done and fault are high for exactly one cycle per request.
- Width rules: addr compare uses the full 32 bits, with no wrap-around. The highest legal word is MEM_WORDS-1; address 4*MEM_WORDS-4 with W is legal.

Test Plan:
- Reset, then SW addr=4 data=32'h1234_5678 -> done 2 cycles after accept, fault=0; LW addr=4 -> rdata=32'h1234_5678.
- After the previous scenario, SB addr=5 data=8'hAB -> RMW_RD then RMW_WR. MemWrite high for 1 cycle with mem_addr=4 and mem_wdata=32'h1234_AB78. done 3 cycles after accept.
- Word 4 = 32'h1234_AB78: LB addr=5 -> 32'hFFFF_FFAB; LBU addr=5 -> 32'h0000_00AB; LH addr=6 -> 32'h0000_1234; LHU addr=4 -> 32'h0000_AB78.
- Faulting requests, each -> done=fault=1 one cycle later, MemRead=MemWrite=0 throughout, memory unchanged:
  - LW addr=6.
  - SH addr=3.
  - LW addr=4*MEM_WORDS.
  - Load funct3=011.
- Back-to-back LW addr=0 then LW addr=8 issued the cycle done rises -> two done pulses 2 cycles apart. req_valid held during a busy cycle -> not accepted twice.
- SB addr=8 with rst_n pulled low during RMW_RD -> MemWrite never asserts, word 8 unchanged, outputs at reset values; after release req_ready=1.
